wallace_final_cpa: RTL and testbench

//  Final carry-propagate stage downstream of the 8x8 Wallace reduction tree. Takes the two

---
 rtl/wallace_pkg.sv | 20 ++
 rtl/cla_group.sv | 53 +++++
 rtl/wallace_final_cpa.sv | 121 ++++++++++++
 tb/tb_wallace_final_cpa.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared constants and the stage-1 pipeline record for the Wallace final
// carry-propagate adder.
package wallace_pkg;

    localparam int W      = 16;
    localparam int GROUP  = 4;
    localparam int NGROUP = W / GROUP;

    // Everything stage 2 needs to finish the add without seeing the operands again
    typedef struct packed {
        logic [W-1:0]      p;
        logic [W-1:0]      gen;
        logic [NGROUP-1:0] grp_g;
        logic [NGROUP-1:0] grp_p;
        logic [W-1:0]      cin0_carries;
        logic [W-1:0]      cin1_carries;
        logic              valid;
    } s1_rec_t;

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead block: bitwise propagate/generate, group G/P, and the
// in-group carry vectors for both possible group carry-ins.
module cla_group
    import wallace_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    output logic [GROUP-1:0] p,
    output logic [GROUP-1:0] gen,
    output logic             grp_g,
    output logic             grp_p,
    output logic [GROUP-1:0] carries_cin0,
    output logic [GROUP-1:0] carries_cin1
);

    logic [GROUP-1:0] p_bits;
    logic [GROUP-1:0] g_bits;

    assign p_bits = a ^ b;
    assign g_bits = a & b;
    assign p      = p_bits;
    assign gen    = g_bits;
    assign grp_p  = &p_bits;

    // Each carry is evaluated independently from bit 0, so every output is a flat
    // lookahead term rather than a chain through the previous carry output.
    always_comb begin
        logic gen_part;
        logic prop_all;
        carries_cin0 = '0;
        carries_cin1 = '0;
        for (int i = 0; i < GROUP; i++) begin
            gen_part = 1'b0;
            prop_all = 1'b1;
            for (int j = 0; j < i; j++) begin
                gen_part = g_bits[j] | (p_bits[j] & gen_part);
                prop_all = prop_all & p_bits[j];
            end
            carries_cin0[i] = gen_part;
            carries_cin1[i] = gen_part | prop_all;
        end
    end

    always_comb begin
        logic gen_all;
        gen_all = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            gen_all = g_bits[j] | (p_bits[j] & gen_all);
        end
        grp_g = gen_all;
    end

endmodule

// File: rtl/wallace_final_cpa.sv
// Two-stage carry-lookahead adder that merges the sum/carry rows of the 8x8
// Wallace tree into the final product on a valid/ready stream.
module wallace_final_cpa
    import wallace_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_product,
    output logic         out_ovf,
    output logic         err_sticky
);

    wire [W-1:0]      p_w;
    wire [W-1:0]      gen_w;
    wire [W-1:0]      c0_w;
    wire [W-1:0]      c1_w;
    wire [NGROUP-1:0] gg_w;
    wire [NGROUP-1:0] gp_w;

    s1_rec_t          s1_d;
    s1_rec_t          s1_q;
    logic             s1_adv;
    logic             s2_adv;
    logic [NGROUP:0]  grp_cin;
    logic [W-1:0]     carries;
    logic [W-1:0]     sum_d;
    logic             ovf_d;
    logic             unused_gen;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_q.valid || s2_adv;
    assign in_ready = s1_adv;

    for (genvar g = 0; g < NGROUP; g++) begin : g_grp
        cla_group u_grp (
            .a            (in_sum[g*GROUP +: GROUP]),
            .b            (in_carry[g*GROUP +: GROUP]),
            .p            (p_w[g*GROUP +: GROUP]),
            .gen          (gen_w[g*GROUP +: GROUP]),
            .grp_g        (gg_w[g]),
            .grp_p        (gp_w[g]),
            .carries_cin0 (c0_w[g*GROUP +: GROUP]),
            .carries_cin1 (c1_w[g*GROUP +: GROUP])
        );
    end

    always_comb begin
        s1_d              = '0;
        s1_d.p            = p_w;
        s1_d.gen          = gen_w;
        s1_d.grp_g        = gg_w;
        s1_d.grp_p        = gp_w;
        s1_d.cin0_carries = c0_w;
        s1_d.cin1_carries = c1_w;
        s1_d.valid        = 1'b1;
    end

    // Operands are only captured with a real beat, so an idle in_valid never loads X data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else if (s1_adv) begin
            if (in_valid) begin
                s1_q <= s1_d;
            end else begin
                s1_q.valid <= 1'b0;
            end
        end
    end

    // Second-level lookahead: each group carry-in is a flat function of the group G/P terms
    always_comb begin
        logic gen_part;
        grp_cin = '0;
        for (int k = 1; k <= NGROUP; k++) begin
            gen_part = 1'b0;
            for (int j = 0; j < k; j++) begin
                gen_part = s1_q.grp_g[j] | (s1_q.grp_p[j] & gen_part);
            end
            grp_cin[k] = gen_part;
        end
    end

    always_comb begin
        carries = '0;
        for (int g = 0; g < NGROUP; g++) begin
            carries[g*GROUP +: GROUP] = grp_cin[g] ? s1_q.cin1_carries[g*GROUP +: GROUP]
                                                   : s1_q.cin0_carries[g*GROUP +: GROUP];
        end
        sum_d = s1_q.p ^ carries;
        ovf_d = grp_cin[NGROUP];
    end

    // gen travels with the record for visibility; the group terms already summarise it
    assign unused_gen = ^s1_q.gen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_product <= '0;
            out_ovf     <= 1'b0;
            err_sticky  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_q.valid;
            if (s1_q.valid) begin
                out_product <= sum_d;
                out_ovf     <= ovf_d;
                if (ovf_d) begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wallace_final_cpa.sv
// Directed scoreboard bench for wallace_final_cpa: expected sums are queued when a
// beat is accepted and compared while the result sits at the output.
module tb_wallace_final_cpa;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic [15:0] in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_ovf;
    logic        err_sticky;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] sb[$];
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;

    wallace_final_cpa dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_carry    (in_carry),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_ovf     (out_ovf),
        .err_sticky  (err_sticky)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic ordy);
        in_valid  = v;
        in_sum    = a;
        in_carry  = b;
        out_ready = ordy;
        #1;
    endtask

    // Compare the presented result with the scoreboard head, then book the handshakes
    task automatic checkOutput();
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'(1'b0));
            end else begin
                if (sb[0][16]) exp_err = 1'b1;
                check("product", 32'(out_product), 32'(sb[0][15:0]));
                check("ovf", 32'(out_ovf), 32'(sb[0][16]));
            end
        end
        check("err_sticky", 32'(err_sticky), 32'(exp_err));
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        if (in_valid && in_ready) sb.push_back({1'b0, in_sum} + {1'b0, in_carry});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic ordy);
        applyStimulus(v, a, b, ordy);
        checkOutput();
        tick();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        $display("[TB] reset state");
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_product", 32'(out_product), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        $display("[TB] basic add and latency");
        step(1'b1, 16'h00FF, 16'h0001, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        check("t1_lat_edge1", 32'(out_valid), 32'd0);
        checkOutput();
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        check("t1_lat_edge2", 32'(out_valid), 32'd1);
        check("t1_product", 32'(out_product), 32'h0100);
        checkOutput();
        tick();
        drain(10);

        $display("[TB] max 8x8 product");
        step(1'b1, 16'hFE00, 16'h0001, 1'b1);
        drain(10);

        $display("[TB] full ripple overflow");
        step(1'b1, 16'hFFFF, 16'h0001, 1'b1);
        drain(10);
        check("t3_err_set", 32'(err_sticky), 32'd1);
        step(1'b1, 16'h0001, 16'h0001, 1'b1);
        step(1'b1, 16'h1234, 16'h0100, 1'b1);
        drain(10);
        check("t3_err_held", 32'(err_sticky), 32'd1);

        $display("[TB] backpressure");
        step(1'b1, 16'h0001, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 16'h0002, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0003, 16'h0003, 1'b0);
            check("t4_in_ready_full", 32'(in_ready), 32'd0);
            check("t4_held_product", 32'(out_product), 32'h0002);
            checkOutput();
            tick();
        end
        step(1'b1, 16'h0003, 16'h0003, 1'b1);
        drain(10);

        $display("[TB] back-to-back throughput");
        for (int j = 0; j < 12; j++) begin
            applyStimulus(j < 8, 16'(j + 1), 16'(j + 1), 1'b1);
            check("t5_out_valid", 32'(out_valid), 32'((j >= 2) && (j < 10)));
            checkOutput();
            tick();
        end
        drain(10);

        $display("[TB] reset mid-flight");
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        step(1'b1, 16'h0004, 16'h0004, 1'b0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        checkOutput();
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_err", 32'(err_sticky), 32'd0);
        sb.delete();
        exp_err = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
        step(1'b1, 16'h0005, 16'h0007, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        check("t6_after_rst_product", 32'(out_product), 32'h000C);
        checkOutput();
        tick();
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
